// File: rtl/subterranean_aead_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : subterranean_aead_ctrl
// Purpose  : Sequencer for the two-lane Subterranean duplex round datapath.
//            Walks init, key, nonce, blank, AD, message, blank and tag phases
//            of one SAE operation, one 64-bit datapath beat at a time.
// Revision : 1.0 - initial release
// ============================================================================
module subterranean_aead_ctrl #(
    parameter int BLANK_BEATS = 4
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          start,
    input  logic          decrypt_mode,
    input  logic [127:0]  key,
    input  logic [127:0]  nonce,
    input  logic [127:0]  tag_in,
    output logic          busy,
    input  logic [63:0]   bd_data,
    input  logic [3:0]    bd_bytes,
    input  logic          bd_last,
    input  logic          bd_valid,
    output logic          bd_ready,
    output logic [63:0]   o_data,
    output logic [3:0]    o_bytes,
    output logic          o_last,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [127:0]  tag_out,
    output logic          tag_valid,
    output logic          tag_ok,
    output logic          dp_init,
    output logic          dp_encrypt,
    output logic          dp_decrypt,
    output logic          dp_enable_round,
    output logic [63:0]   dp_din,
    output logic [5:0]    dp_din_size,
    output logic          dp_din_valid,
    input  logic          dp_din_ready,
    input  logic [63:0]   dp_dout,
    input  logic          dp_dout_valid,
    output logic          dp_dout_ready
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        KEY     = 4'd2,
        NONCE   = 4'd3,
        BLANK1  = 4'd4,
        AD      = 4'd5,
        AD_PAD  = 4'd6,
        MSG     = 4'd7,
        MSG_PAD = 4'd8,
        BLANK2  = 4'd9,
        TAG     = 4'd10,
        DONE    = 4'd11
    } state_t;

    // The shared beat counter is two bits wide, so BLANK_BEATS tops out at 4.
    localparam logic [1:0] BLANK_LAST = 2'(BLANK_BEATS - 1);

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           dec_q, dec_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [127:0]   tagin_q, tagin_d;
    logic [127:0]   tag_q, tag_d;
    logic [127:0]   word_sel;
    logic [6:0]     bd_map;

    // Host byte count -> {enable_round, lane2 size, lane1 size}
    function automatic logic [6:0] map_bytes(input logic [3:0] b);
        if (b < 4'd4)      return {1'b0, 3'd0, b[2:0]};
        else if (b < 4'd8) return {1'b1, 1'b0, b[1:0], 3'd4};
        else               return {1'b1, 6'o44};
    endfunction

    assign bd_map   = map_bytes(bd_bytes);
    assign word_sel = (state_q == KEY) ? key_q : nonce_q;
    assign tag_out  = tag_q;

    // State, beat counter and captured operation parameters
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            dec_q   <= 1'b0;
            key_q   <= '0;
            nonce_q <= '0;
            tagin_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            tagin_q <= tagin_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state logic and all handshake / datapath control decoded from state
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dec_d           = dec_q;
        key_d           = key_q;
        nonce_d         = nonce_q;
        tagin_d         = tagin_q;
        tag_d           = tag_q;
        busy            = (state_q != IDLE);
        bd_ready        = 1'b0;
        o_data          = '0;
        o_bytes         = '0;
        o_last          = 1'b0;
        o_valid         = 1'b0;
        tag_valid       = 1'b0;
        tag_ok          = 1'b0;
        dp_init         = 1'b0;
        dp_encrypt      = 1'b0;
        dp_decrypt      = 1'b0;
        dp_enable_round = 1'b0;
        dp_din          = '0;
        dp_din_size     = '0;
        dp_din_valid    = 1'b0;
        dp_dout_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d   = decrypt_mode;
                    key_d   = key;
                    nonce_d = nonce;
                    tagin_d = tag_in;
                    tag_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                dp_init = 1'b1;
                cnt_d   = 2'd0;
                state_d = KEY;
            end
            KEY, NONCE: begin
                dp_din_valid  = 1'b1;
                dp_dout_ready = 1'b1;
                if (cnt_q == 2'd0) begin
                    dp_din          = word_sel[63:0];
                    dp_din_size     = 6'o44;
                    dp_enable_round = 1'b1;
                end else if (cnt_q == 2'd1) begin
                    dp_din          = word_sel[127:64];
                    dp_din_size     = 6'o44;
                    dp_enable_round = 1'b1;
                end
                if (dp_din_ready) begin
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = (state_q == KEY) ? NONCE : BLANK1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            BLANK1, BLANK2: begin
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
                dp_enable_round = 1'b1;
                if (dp_din_ready) begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = 2'd0;
                        state_d = (state_q == BLANK1) ? AD : TAG;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            AD: begin
                dp_din_valid    = bd_valid;
                bd_ready        = dp_din_ready;
                dp_dout_ready   = 1'b1;
                dp_din          = bd_data;
                dp_din_size     = bd_map[5:0];
                dp_enable_round = bd_map[6];
                if (bd_valid && dp_din_ready && bd_last)
                    state_d = (bd_bytes >= 4'd8) ? AD_PAD : MSG;
            end
            MSG: begin
                dp_din_valid    = bd_valid;
                bd_ready        = dp_din_ready;
                dp_dout_ready   = o_ready;
                dp_din          = bd_data;
                dp_din_size     = bd_map[5:0];
                dp_enable_round = bd_map[6];
                dp_encrypt      = ~dec_q;
                dp_decrypt      = dec_q;
                o_valid         = dp_dout_valid;
                o_bytes         = bd_bytes;
                o_last          = bd_last;
                for (int i = 0; i < 8; i++) begin
                    if (4'(i) < bd_bytes)
                        o_data[8*i +: 8] = dp_dout[8*i +: 8];
                end
                if (bd_valid && dp_din_ready && o_ready && bd_last)
                    state_d = (bd_bytes >= 4'd8) ? MSG_PAD : BLANK2;
            end
            AD_PAD, MSG_PAD: begin
                // Empty padding block after a phase that ended on a full word
                dp_din_valid  = 1'b1;
                dp_dout_ready = 1'b1;
                if (dp_din_ready) begin
                    cnt_d   = 2'd0;
                    state_d = (state_q == AD_PAD) ? MSG : BLANK2;
                end
            end
            TAG: begin
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
                dp_enable_round = 1'b1;
                if (dp_din_ready) begin
                    if (cnt_q == 2'd0) begin
                        tag_d[63:0] = dp_dout;
                        cnt_d       = 2'd1;
                    end else begin
                        tag_d[127:64] = dp_dout;
                        cnt_d         = 2'd0;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                tag_valid = 1'b1;
                tag_ok    = dec_q && (tag_q == tagin_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_subterranean_aead_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_subterranean_aead_ctrl
// Purpose  : Directed self-checking bench for subterranean_aead_ctrl with a
//            toy duplex datapath that keeps encrypt/decrypt symmetric.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subterranean_aead_ctrl;

    localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] N1 = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] K2 = 128'hA5A5_0123_4567_89AB_CDEF_F00D_BEEF_5A5A;
    localparam logic [127:0] N2 = 128'h3C3C_1122_3344_5566_7788_99AA_BBCC_DDEE;
    localparam logic [63:0]  P0 = 64'h8877665544332211;
    localparam logic [63:0]  P1 = 64'hFFEEDDCCBBAA9988;
    localparam logic [63:0]  M5 = 64'h000000FFFFFFFFFF;

    logic clk = 1'b0, arstn = 1'b0;
    logic start = 0, decrypt_mode = 0;
    logic [127:0] key = '0, nonce = '0, tag_in = '0;
    logic busy;
    logic [63:0] bd_data = '0;
    logic [3:0]  bd_bytes = '0;
    logic bd_last = 0, bd_valid = 0, bd_ready;
    logic [63:0] o_data;
    logic [3:0]  o_bytes;
    logic o_last, o_valid, o_ready = 1'b1;
    logic [127:0] tag_out;
    logic tag_valid, tag_ok;
    logic dp_init, dp_encrypt, dp_decrypt, dp_enable_round;
    logic [63:0] dp_din, dp_dout;
    logic [5:0]  dp_din_size;
    logic dp_din_valid, dp_din_ready, dp_dout_valid, dp_dout_ready;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    subterranean_aead_ctrl #(.BLANK_BEATS(4)) dut (
        .clk(clk), .arstn(arstn), .start(start), .decrypt_mode(decrypt_mode),
        .key(key), .nonce(nonce), .tag_in(tag_in), .busy(busy),
        .bd_data(bd_data), .bd_bytes(bd_bytes), .bd_last(bd_last),
        .bd_valid(bd_valid), .bd_ready(bd_ready),
        .o_data(o_data), .o_bytes(o_bytes), .o_last(o_last),
        .o_valid(o_valid), .o_ready(o_ready),
        .tag_out(tag_out), .tag_valid(tag_valid), .tag_ok(tag_ok),
        .dp_init(dp_init), .dp_encrypt(dp_encrypt), .dp_decrypt(dp_decrypt),
        .dp_enable_round(dp_enable_round), .dp_din(dp_din),
        .dp_din_size(dp_din_size), .dp_din_valid(dp_din_valid),
        .dp_din_ready(dp_din_ready), .dp_dout(dp_dout),
        .dp_dout_valid(dp_dout_valid), .dp_dout_ready(dp_dout_ready)
    );

    // Toy datapath: output = state ^ din while en/decrypting, state otherwise;
    // the state absorbs the plaintext, so decrypt retraces the encrypt states.
    logic [63:0] ms = '0, ms_nxt = '0;
    logic        ms_pend = 1'b0;
    assign dp_din_ready  = dp_dout_ready;
    assign dp_dout_valid = dp_din_valid;
    assign dp_dout       = (dp_encrypt | dp_decrypt) ? (ms ^ dp_din) : ms;

    function automatic logic [63:0] mix(input logic [63:0] x);
        return {x[50:0], x[63:51]} ^ (x >> 7) ^ 64'h9E3779B97F4A7C15;
    endfunction

    function automatic logic [63:0] absorb(input logic [63:0] s, input logic [63:0] d,
                                           input logic [5:0] sz, input logic en);
        logic [63:0] m, x;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(sz[2:0])) m[8*i +: 8] = d[8*i +: 8];
            if (i < int'(sz[5:3])) m[32+8*i +: 8] = d[32+8*i +: 8];
        end
        x = mix(s ^ m ^ {58'd0, sz});
        if (en) x = mix(x);
        return x;
    endfunction

    // Commit log, output capture and tag capture
    logic [63:0] lg_din [256];
    logic [63:0] lg_dout[256];
    logic [5:0]  lg_size[256];
    logic        lg_en  [256];
    logic        lg_enc [256];
    logic        lg_dec [256];
    int          ncm = 0, init_cyc = -1, init_cnt = 0;
    int          tv_cnt = 0, tv_cyc = -1;
    logic        tv_ok = 1'b0;
    logic [127:0] tv_tag = '0, tv_exp = '0;
    logic [63:0] oq_data[$];
    logic [3:0]  oq_bytes[$];
    logic        oq_last[$];

    always @(negedge clk) begin
        ms_pend = 1'b0;
        if (dp_init) begin
            init_cyc = cyc; init_cnt++; ms_nxt = '0; ms_pend = 1'b1;
        end
        if (dp_din_valid && dp_din_ready && dp_dout_ready) begin
            if (ncm < 256) begin
                lg_din[ncm] = dp_din;   lg_dout[ncm] = dp_dout;
                lg_size[ncm] = dp_din_size; lg_en[ncm] = dp_enable_round;
                lg_enc[ncm] = dp_encrypt;   lg_dec[ncm] = dp_decrypt;
            end
            ms_nxt  = absorb(ms, dp_decrypt ? dp_dout : dp_din, dp_din_size, dp_enable_round);
            ms_pend = 1'b1;
            ncm++;
        end
        if (o_valid && o_ready) begin
            oq_data.push_back(o_data); oq_bytes.push_back(o_bytes); oq_last.push_back(o_last);
        end
        if (tag_valid) begin
            tv_cnt++; tv_cyc = cyc; tv_ok = tag_ok; tv_tag = tag_out;
            tv_exp = {lg_dout[(ncm-1) & 255], lg_dout[(ncm-2) & 255]};
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ms_pend) ms <= ms_nxt;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [3:0] b, input logic l);
        bit acc;
        acc = 1'b0;
        bd_data = d; bd_bytes = b; bd_last = l; bd_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = bd_ready;
        end
        if (!acc) check("bd_accept_timeout", acc, 1);
        @(posedge clk); #1;
        bd_valid = 1'b0; bd_data = '0; bd_bytes = '0; bd_last = 1'b0;
    endtask

    task automatic wait_tag(input int tv0);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = (tv_cnt > tv0);
        end
        if (!got) check("tag_timeout", got, 1);
        @(posedge clk); #1;
    endtask

    // One full operation; entered and left just after a rising edge.
    task automatic run_op(input logic [127:0] k, input logic [127:0] n, input logic [127:0] ti,
                          input logic dec, input logic [63:0] ad, input logic [3:0] adb,
                          input int nmsg, input logic [63:0] m0, input logic [63:0] m1,
                          input logic [3:0] mlb, input int gap, input int stall, input bit pulse,
                          output int t0, output int base, output int obase);
        int tv0, n0;
        logic [63:0] d0;
        base = ncm; obase = oq_data.size(); tv0 = tv_cnt;
        key = k; nonce = n; tag_in = ti; decrypt_mode = dec; start = 1'b1; t0 = cyc;
        @(posedge clk); #1; start = 1'b0;
        if (pulse) begin
            key = ~k; nonce = ~n; tag_in = ti ^ 128'd1; decrypt_mode = ~dec; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        // Slow host: first AD beat one cycle after the phase opens, one idle
        // cycle between AD and message.
        if (gap > 0) while (cyc < t0 + 13) begin @(posedge clk); #1; end
        send(ad, adb, 1'b1);
        if (gap > 0) begin @(posedge clk); #1; end
        if (nmsg == 2) send(m0, 4'd8, 1'b0);
        if (stall > 0) begin
            n0 = ncm;
            bd_data = m1; bd_bytes = mlb; bd_last = 1'b1; bd_valid = 1'b1; o_ready = 1'b0;
            @(negedge clk);
            d0 = o_data;
            check("stall_bd_ready", bd_ready, 0);
            check("stall_o_valid", o_valid, 1);
            repeat (stall - 1) @(negedge clk);
            check("stall_no_commit", ncm, n0);
            check("stall_data_hold", o_data, d0);
            @(posedge clk); #1; o_ready = 1'b1;
        end
        send((nmsg == 2) ? m1 : m0, mlb, 1'b1);
        wait_tag(tv0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, b, ob, ic0, tv0;
        logic [127:0] tg2;
        logic [63:0] c0, c1;

        repeat (3) @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_tag_valid", {tag_valid, tag_ok}, 0);
        check("rst_dp_ctrl", {dp_init, dp_din_valid, dp_dout_ready, dp_enable_round}, 0);
        check("rst_handshake", {bd_ready, o_valid}, 0);
        arstn = 1'b1;
        @(posedge clk); #1;

        // Op 1: encrypt, empty AD, empty message, slow host
        run_op(K1, N1, '0, 1'b0, '0, 4'd0, 1, '0, '0, 4'd0, 1, 0, 1'b0, t0, b, ob);
        check("op1_init_cycle", init_cyc, t0 + 1);
        check("op1_key_sizes", {lg_size[b], lg_size[b+1], lg_size[b+2]}, {6'o44, 6'o44, 6'o00});
        check("op1_key_en", {lg_en[b], lg_en[b+1], lg_en[b+2]}, 3'b110);
        check("op1_key_word01", lg_din[b], K1[63:0]);
        check("op1_nonce_word23", lg_din[b+4], N1[127:64]);
        check("op1_ad_beat", {lg_size[b+10], lg_en[b+10]}, {6'd0, 1'b0});
        check("op1_msg_beat", {lg_size[b+11], lg_en[b+11], lg_enc[b+11], lg_dec[b+11]},
              {6'd0, 1'b0, 1'b1, 1'b0});
        check("op1_blank2", {lg_en[b+12], lg_en[b+13], lg_en[b+14], lg_en[b+15],
              lg_size[b+12], lg_size[b+15]}, {4'hF, 12'd0});
        check("op1_commits", ncm - b, 18);
        check("op1_tag_cycle", tv_cyc, t0 + 22);
        check("op1_tag_ok", tv_ok, 0);
        check("op1_tag_out", tv_tag, tv_exp);
        check("op1_out_count", oq_data.size() - ob, 1);
        check("op1_out_beat", {oq_data[ob], oq_bytes[ob], oq_last[ob]}, {64'd0, 4'd0, 1'b1});
        check("op1_tag_hold", tag_out, tv_exp);
        check("op1_idle", busy, 0);

        // Op 2: encrypt, 3-byte AD, 13-byte message with output stall
        run_op(K2, N2, '0, 1'b0, 64'h0000000000CCBBAA, 4'd3, 2, P0, P1, 4'd5, 0, 3, 1'b0, t0, b, ob);
        check("op2_ad_beat", {lg_size[b+10], lg_en[b+10]}, {6'd3, 1'b0});
        check("op2_msg_b0", {lg_size[b+11], lg_en[b+11], lg_enc[b+11]}, {6'o44, 1'b1, 1'b1});
        check("op2_msg_b1", {lg_size[b+12], lg_en[b+12], lg_enc[b+12]}, {6'o14, 1'b1, 1'b1});
        check("op2_no_pad", {lg_size[b+13], lg_en[b+13]}, {6'd0, 1'b1});
        check("op2_out_count", oq_data.size() - ob, 2);
        check("op2_out_last", {oq_last[ob], oq_last[ob+1], oq_bytes[ob+1]}, {1'b0, 1'b1, 4'd5});
        check("op2_out_mask", oq_data[ob+1] & ~M5, 0);
        check("op2_tag_out", tv_tag, tv_exp);
        c0 = oq_data[ob]; c1 = oq_data[ob+1]; tg2 = tv_tag;

        // Op 3: full-word AD and message, both followed by a pad beat
        run_op(K1, N2, '0, 1'b0, P1, 4'd8, 1, P0, '0, 4'd8, 0, 0, 1'b0, t0, b, ob);
        check("op3_ad_beat", {lg_size[b+10], lg_en[b+10]}, {6'o44, 1'b1});
        check("op3_ad_pad", {lg_size[b+11], lg_en[b+11]}, {6'd0, 1'b0});
        check("op3_msg_beat", {lg_size[b+12], lg_en[b+12], lg_enc[b+12]}, {6'o44, 1'b1, 1'b1});
        check("op3_msg_pad", {lg_size[b+13], lg_en[b+13], lg_enc[b+13], lg_dec[b+13]}, 0);
        check("op3_commits", ncm - b, 20);
        check("op3_out_count", oq_data.size() - ob, 1);

        // Op 4: decrypt op 2's ciphertext; a start pulse mid-op must be ignored
        ic0 = init_cnt;
        run_op(K2, N2, tg2, 1'b1, 64'h0000000000CCBBAA, 4'd3, 2, c0, c1, 4'd5, 0, 0, 1'b1, t0, b, ob);
        check("op4_single_init", init_cnt - ic0, 1);
        check("op4_key_word23", lg_din[b+1], K2[127:64]);
        check("op4_nonce_word01", lg_din[b+3], N2[63:0]);
        check("op4_msg_dir", {lg_enc[b+11], lg_dec[b+11]}, 2'b01);
        check("op4_plain0", oq_data[ob], P0);
        check("op4_plain1", oq_data[ob+1], P1 & M5);
        check("op4_tag_ok", tv_ok, 1);

        // Op 5: same decrypt with a corrupted expected tag
        run_op(K2, N2, tg2 ^ 128'd1, 1'b1, 64'h0000000000CCBBAA, 4'd3, 2, c0, c1, 4'd5, 0, 0, 1'b0,
               t0, b, ob);
        check("op5_plain0", oq_data[ob], P0);
        check("op5_tag_bad", tv_ok, 0);

        // Op 6: reset while a message beat is stalled in MSG
        tv0 = tv_cnt;
        key = K1; nonce = N1; decrypt_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        send('0, 4'd0, 1'b1);
        bd_data = P0; bd_bytes = 4'd8; bd_last = 1'b1; bd_valid = 1'b1; o_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("op6_pre_busy", {busy, o_valid}, 2'b11);
        arstn = 1'b0;
        #1;
        check("op6_rst_ctrl", {busy, o_valid, bd_ready, dp_din_valid, dp_dout_ready, tag_valid},
              0);
        check("op6_rst_data", {o_data, o_bytes, o_last, tag_out}, 0);
        bd_valid = 1'b0; bd_last = 1'b0; o_ready = 1'b1;
        @(posedge clk); #1; arstn = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("op6_no_tag", tv_cnt - tv0, 0);

        // Op 7: normal operation after the abort
        run_op(K1, N1, '0, 1'b0, '0, 4'd0, 1, '0, '0, 4'd0, 0, 0, 1'b0, t0, b, ob);
        check("op7_tag_count", tv_cnt - tv0, 1);
        check("op7_commits", ncm - b, 18);
        check("op7_tag_out", tv_tag, tv_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subterranean_aead_ctrl.md
Name: subterranean_aead_ctrl

Overview:
- Sequencer for the two-lane Subterranean duplex round datapath, which performs one or two rounds per accepted 64-bit beat.
- Runs a full SAE operation: state init, key absorb, nonce absorb, blank rounds, AD absorb, message en/decrypt, blank rounds, tag squeeze.
- Data AD and message share one host input stream. The message result leaves on an output stream; the tag is presented on a held register with a one-cycle valid.

Parameters:
BLANK_BEATS, 4, blank two-round beats after nonce and after message (4 beats = 8 rounds)

Ports:
clk  in  1  clock
arstn  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
decrypt_mode  in  1  1=decrypt, 0=encrypt; captured at start
key  in  128  captured at start; word order key[31:0] first
nonce  in  128  captured at start; same order
tag_in  in  128  expected tag for decrypt; captured at start
busy  out  1  high whenever state is not IDLE
bd_data  in  64  AD/message beat; byte 0 = [7:0]
bd_bytes  in  4  valid bytes, 0..8; only the last beat may be less than 8
bd_last  in  1  last beat of the current phase (AD, then message)
bd_valid  in  1  beat valid
bd_ready  out  1  beat accepted when valid & ready
o_data  out  64  message result; bytes at index >= o_bytes forced to 0
o_bytes  out  4  copy of bd_bytes
o_last  out  1  copy of bd_last
o_valid  out  1  result valid
o_ready  in  1  result consumed
tag_out  out  128  squeezed tag; beat0 fills [63:0]
tag_valid  out  1  one-cycle pulse
tag_ok  out  1  decrypt and tag_out==tag_in; valid with tag_valid
dp_init  out  1  datapath state clear
dp_encrypt  out  1  datapath encrypt
dp_decrypt  out  1  datapath decrypt
dp_enable_round  out  1  1 = two rounds this beat, 0 = lane 1 only
dp_din  out  64  datapath input
dp_din_size  out  6  {lane2[2:0], lane1[2:0]}; 0..3 = bytes, 4 = full word
dp_din_valid  out  1  beat valid
dp_din_ready  in  1  datapath ready
dp_dout  in  64  datapath output
dp_dout_valid  in  1  datapath output valid
dp_dout_ready  out  1  datapath output ready; beat commits on dp_din_valid & dp_dout_ready

Behaviour:
- Reset: state IDLE, counter 0. Every output is 0, including tag_out and captured registers. An asynchronous reset mid-operation aborts immediately and emits no tag.
- FSM is registered; dp_* outputs and the bd/o handshake signals are combinational from state.
- States: IDLE, INIT, KEY, NONCE, BLANK1, AD, AD_PAD, MSG, MSG_PAD, BLANK2, TAG, DONE. A 2-bit beat counter is shared.
- IDLE: when start=1, capture inputs and go to INIT. A start received in any other state is ignored.
- INIT: dp_init=1 for one cycle, then KEY.
- KEY / NONCE: 3 beats each, with dp_din_valid=1, dp_dout_ready=1, and enc=dec=0.
  - Beat 0: words 0,1; size 6'o44; enable_round=1.
  - Beat 1: words 2,3; size 6'o44; enable_round=1.
  - Beat 2: din=0; size 0; enable_round=0 (empty pad block).
- BLANK1 / BLANK2: BLANK_BEATS beats with din=0, size 0, enable_round=1.
- AD / MSG: pass-through handshake.
  - dp_din_valid=bd_valid; bd_ready=dp_din_ready.
  - AD: dp_dout_ready=1, o_valid=0.
  - MSG: dp_dout_ready=o_ready, o_valid=dp_dout_valid, o_data=masked dp_dout, dp_encrypt=~decrypt_mode, dp_decrypt=decrypt_mode.
- Beat size mapping, with b = bd_bytes:
  - b <= 3: lane1 = b, enable_round=0.
  - 4 <= b <= 7: lane1 = 4, lane2 = b-4, enable_round=1.
  - b = 8: size 6'o44, enable_round=1.
  - A non-last beat must have b=8; violating this is undefined.
- Phase exit on an accepted beat with bd_last=1:
  - b=8: go to AD_PAD / MSG_PAD, which issue one internal beat (din=0, size 0, enable_round=0). In MSG_PAD, enc=dec=0 and no output is produced.
  - b<8: go straight to the next phase (AD to MSG, MSG to BLANK2).
  - Empty AD or message is signalled by bd_last with b=0, which gives one lane-1 pad beat.
- TAG: 2 beats with din=0, size 0, enable_round=1, enc=dec=0 (full output mask). dp_dout is latched into tag_out[63:0], then into [127:64].
- DONE: tag_valid=1 and tag_ok valid for one cycle, then IDLE. tag_out holds until the next start.
- Latency: with start in cycle T, INIT is T+1, KEY T+2..4, NONCE T+5..7, BLANK1 T+8..11, and the first AD beat is accepted no earlier than T+12.
- Stalls: no beat commits unless dp_din_valid & dp_dout_ready. In MSG, a low o_ready holds the datapath state and bd_ready follows dp_din_ready.

Test Plan:
- Encrypt, empty AD (bd_bytes=0, last), empty message -> dp_init at T+1; KEY sizes 6'o44, 6'o44, 6'o00 with enable_round 1,1,0; AD and MSG one beat each with enable_round=0; 4 BLANK2 beats; tag_valid at T+22; tag_ok=0.
- AD of 3 bytes, then AD of 8 bytes (last) -> first beat: size 6'd3, enable_round=0. Second: size 6'o44, enable_round=1, followed by one AD_PAD beat with size 0, enable_round=0.
- Message of 13 bytes (8, then 5 last) with o_ready low for 3 cycles on beat 2 -> no state change during the stall; o_data bytes 5..7 = 0; o_bytes=5; o_last=1.
- Encrypt, then decrypt the ciphertext with tag_in = the produced tag -> plaintext restored, tag_ok=1. Flip tag_in bit 0 -> tag_ok=0.
- Reset asserted during MSG -> busy=0, tag_valid=0, and all outputs 0 asynchronously. A new start after release completes normally.
- start pulsed while busy -> ignored; captured key and nonce unchanged.
